// File: rtl/pet_royale_pkg.sv
// Shared encodings for the pet royale combat datapath: pet word layout,
// action codes, player indices and the resolver FSM state type.
package pet_royale_pkg;

    localparam int PET_W   = 9;
    localparam int FIELD_W = 3;
    localparam int HP_LSB  = 0;
    localparam int DEF_LSB = 3;
    localparam int ATK_LSB = 6;
    localparam logic [FIELD_W-1:0] HP_MAX = 3'd7;

    localparam logic [1:0] ACT_ATTACK = 2'd0;
    localparam logic [1:0] ACT_DEFEND = 2'd1;
    localparam logic [1:0] ACT_HEAL   = 2'd2;
    localparam logic [1:0] ACT_SKIP   = 2'd3;

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CALC,
        ST_APPLY,
        ST_DONE
    } state_e;

    function automatic logic [FIELD_W-1:0] hp_of(input logic [PET_W-1:0] w);
        return w[HP_LSB +: FIELD_W];
    endfunction

endpackage

// File: rtl/combat_damage_calc.sv
// Combinational attack resolution: mitigation, minimum-one damage, optional
// critical doubling (saturating at 15) and the defender's resulting HP.
module combat_damage_calc
    import pet_royale_pkg::*;
(
    input  logic [FIELD_W-1:0] atk_i,
    input  logic [FIELD_W-1:0] def_i,
    input  logic [FIELD_W-1:0] hp_i,
    input  logic               blocking_i,
    input  logic               crit_i,
    output logic [3:0]         damage_o,
    output logic [FIELD_W-1:0] new_hp_o
);

    logic [FIELD_W-1:0] mitig;
    logic signed [3:0]  raw;
    logic [3:0]         base;
    logic [4:0]         dbl;

    always_comb begin
        mitig = blocking_i ? def_i : {1'b0, def_i[2:1]};
        raw   = $signed({1'b0, atk_i}) - $signed({1'b0, mitig});
        base  = (raw < 4'sd1) ? 4'd1 : $unsigned(raw);
        dbl   = {base, 1'b0};
        if (crit_i) begin
            damage_o = (dbl > 5'd15) ? 4'd15 : dbl[3:0];
        end else begin
            damage_o = base;
        end
        // hp_i > damage implies damage fits in three bits
        new_hp_o = ({1'b0, hp_i} > damage_o) ? (hp_i - damage_o[2:0]) : 3'd0;
    end

endmodule

// File: rtl/combat_resolver.sv
// Pet stat file plus a five-state action resolver (IDLE/FETCH/CALC/APPLY/DONE).
// Define COMBAT_CRIT_EN to add the crit_roll input and critical-hit doubling.
module combat_resolver
    import pet_royale_pkg::*;
#(
    parameter int HEAL_AMT    = 2,
    parameter int CRIT_THRESH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [2:0]       load_addr,
    input  logic [PET_W-1:0] load_data,
    input  logic             start,
    input  logic             attacker_player,
    input  logic [1:0]       attacker_idx,
    input  logic [1:0]       defender_idx,
    input  logic [1:0]       action,
`ifdef COMBAT_CRIT_EN
    input  logic [7:0]       crit_roll,
`endif
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [3:0]       damage_out,
    output logic             defender_ko,
    output logic [1:0]       team_wiped,
    input  logic [2:0]       rd_addr,
    output logic [PET_W-1:0] rd_data
);

    state_e             state_q, state_d;
    logic [PET_W-1:0]   stats_q [8];
    logic [1:0]         block_q;

    logic               req_player_q;
    logic [1:0]         req_att_idx_q, req_def_idx_q, req_action_q;
    logic [PET_W-1:0]   att_word_q, def_word_q;
    logic               def_block_q, illegal_q, crit_hit;
    logic [3:0]         dmg_q, calc_damage;
    logic [FIELD_W-1:0] new_hp_q, calc_new_hp, heal_hp;
    logic [4:0]         heal_sum;
    logic               res_illegal_q, res_ko_q;
    logic [3:0]         res_damage_q;

    logic [2:0]         att_addr, def_addr, wr_addr;
    logic [PET_W-1:0]   wr_data;
    logic               wr_en, fetch_illegal;

    assign att_addr = {req_player_q, req_att_idx_q};
    assign def_addr = {~req_player_q, req_def_idx_q};

    assign fetch_illegal = (hp_of(stats_q[att_addr]) == 3'd0) ||
                           ((req_action_q == ACT_ATTACK) && (hp_of(stats_q[def_addr]) == 3'd0));

`ifdef COMBAT_CRIT_EN
    logic crit_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            crit_q <= 1'b0;
        end else if (state_q == ST_FETCH) begin
            crit_q <= (crit_roll < 8'(CRIT_THRESH));
        end
    end
    assign crit_hit = crit_q;
`else
    assign crit_hit = 1'b0;
`endif

    combat_damage_calc u_calc (
        .atk_i      (att_word_q[ATK_LSB +: FIELD_W]),
        .def_i      (def_word_q[DEF_LSB +: FIELD_W]),
        .hp_i       (hp_of(def_word_q)),
        .blocking_i (def_block_q),
        .crit_i     (crit_hit),
        .damage_o   (calc_damage),
        .new_hp_o   (calc_new_hp)
    );

    assign heal_sum = {2'b00, hp_of(att_word_q)} + 5'(HEAL_AMT);
    assign heal_hp  = (heal_sum > {2'b00, HP_MAX}) ? HP_MAX : heal_sum[2:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && !load_en) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_CALC;
            ST_CALC:  state_d = ST_APPLY;
            ST_APPLY: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            block_q       <= 2'b00;
            req_player_q  <= 1'b0;
            req_att_idx_q <= 2'd0;
            req_def_idx_q <= 2'd0;
            req_action_q  <= ACT_ATTACK;
            att_word_q    <= '0;
            def_word_q    <= '0;
            def_block_q   <= 1'b0;
            illegal_q     <= 1'b0;
            dmg_q         <= 4'd0;
            new_hp_q      <= 3'd0;
            res_illegal_q <= 1'b0;
            res_damage_q  <= 4'd0;
            res_ko_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start && !load_en) begin
                        req_player_q  <= attacker_player;
                        req_att_idx_q <= attacker_idx;
                        req_def_idx_q <= defender_idx;
                        req_action_q  <= action;
                        res_illegal_q <= 1'b0;
                        res_damage_q  <= 4'd0;
                        res_ko_q      <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    att_word_q  <= stats_q[att_addr];
                    def_word_q  <= stats_q[def_addr];
                    def_block_q <= block_q[~req_player_q];
                    illegal_q   <= fetch_illegal;
                    // Acting clears its own guard so a defend lasts one opposing turn
                    if (!fetch_illegal) block_q[req_player_q] <= 1'b0;
                end
                ST_CALC: begin
                    dmg_q    <= calc_damage;
                    new_hp_q <= calc_new_hp;
                end
                ST_APPLY: begin
                    res_illegal_q <= illegal_q;
                    if (!illegal_q) begin
                        if (req_action_q == ACT_ATTACK) begin
                            res_damage_q           <= dmg_q;
                            res_ko_q               <= (new_hp_q == 3'd0);
                            block_q[~req_player_q] <= 1'b0;
                        end else if (req_action_q == ACT_DEFEND) begin
                            block_q[req_player_q] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = load_addr;
        wr_data = load_data;
        if ((state_q == ST_IDLE) && load_en) begin
            wr_en = 1'b1;
        end else if ((state_q == ST_APPLY) && !illegal_q) begin
            if (req_action_q == ACT_ATTACK) begin
                wr_en   = 1'b1;
                wr_addr = def_addr;
                wr_data = {def_word_q[PET_W-1:FIELD_W], new_hp_q};
            end else if (req_action_q == ACT_HEAL) begin
                wr_en   = 1'b1;
                wr_addr = att_addr;
                wr_data = {att_word_q[PET_W-1:FIELD_W], heal_hp};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) stats_q[i] <= '0;
        end else if (wr_en) begin
            stats_q[wr_addr] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wipe
            assign team_wiped[gi] = ~|{hp_of(stats_q[4*gi]),   hp_of(stats_q[4*gi+1]),
                                       hp_of(stats_q[4*gi+2]), hp_of(stats_q[4*gi+3])};
        end
    endgenerate

    assign rd_data     = stats_q[rd_addr];
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign illegal     = res_illegal_q;
    assign damage_out  = res_damage_q;
    assign defender_ko = res_ko_q;

endmodule

// File: tb/tb_combat_resolver.sv
// Directed bench for combat_resolver; crit checks are built only when
// COMBAT_CRIT_EN is defined.
`timescale 1ns/1ps
module tb_combat_resolver;
    import pet_royale_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_en = 1'b0;
    logic [2:0] load_addr = 3'd0;
    logic [8:0] load_data = 9'd0;
    logic       start = 1'b0;
    logic       attacker_player = 1'b0;
    logic [1:0] attacker_idx = 2'd0;
    logic [1:0] defender_idx = 2'd0;
    logic [1:0] action = 2'd0;
    logic [7:0] crit_roll = 8'd255;
    logic       busy, done, illegal, defender_ko;
    logic [3:0] damage_out;
    logic [1:0] team_wiped;
    logic [2:0] rd_addr = 3'd0;
    logic [8:0] rd_data;

    int checks = 0;
    int errors = 0;
    int lat, busy_cnt;
    logic [8:0] word;

    combat_resolver dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .attacker_player(attacker_player),
        .attacker_idx(attacker_idx), .defender_idx(defender_idx), .action(action),
`ifdef COMBAT_CRIT_EN
        .crit_roll(crit_roll),
`endif
        .busy(busy), .done(done), .illegal(illegal), .damage_out(damage_out),
        .defender_ko(defender_ko), .team_wiped(team_wiped),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] pet(input int atk, input int def, input int hp);
        return {3'(atk), 3'(def), 3'(hp)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 10 && busy; g++) tick();
    endtask

    task automatic load(input logic [2:0] a, input logic [8:0] d);
        wait_idle();
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic peek(input logic [2:0] a, output logic [8:0] d);
        rd_addr = a;
        @(negedge clk);
        d = rd_data;
        tick();
    endtask

    task automatic run_action(input logic p, input logic [1:0] ai, input logic [1:0] di,
                              input logic [1:0] act);
        wait_idle();
        attacker_player = p; attacker_idx = ai; defender_idx = di; action = act;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 12) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d exp 0", done); end
        checks++; if ({illegal, defender_ko, damage_out} !== 6'd0) begin errors++;
            $display("FAIL reset_results got %0d/%0d/%0d exp 0/0/0", illegal, defender_ko, damage_out); end
        checks++; if (team_wiped !== 2'b11) begin errors++; $display("FAIL reset_wiped got %b exp 11", team_wiped); end
        reset = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_attack();
        load(3'd0, pet(5, 2, 6));
        load(3'd4, pet(3, 4, 7));
        checks++; if (team_wiped !== 2'b00) begin errors++; $display("FAIL load_wiped got %b exp 00", team_wiped); end
        run_action(PLAYER1, 2'd0, 2'd0, ACT_ATTACK);
        checks++; if (lat !== 4) begin errors++; $display("FAIL attack_latency got %0d exp 4", lat); end
        checks++; if (damage_out !== 4'd3) begin errors++; $display("FAIL attack_damage got %0d exp 3", damage_out); end
        checks++; if ({illegal, defender_ko} !== 2'b00) begin errors++;
            $display("FAIL attack_flags got %b exp 00", {illegal, defender_ko}); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL done_pulse got done=%0d busy=%0d exp 0 0", done, busy); end
        peek(3'd4, word);
        checks++; if (word !== pet(3, 4, 4)) begin errors++; $display("FAIL attack_hp got %h exp %h", word, pet(3, 4, 4)); end
        $display("test_attack done");
    endtask

    task automatic test_block();
        run_action(PLAYER2, 2'd0, 2'd0, ACT_DEFEND);
        checks++; if ({illegal, damage_out} !== 5'd0) begin errors++;
            $display("FAIL defend_result got %0d/%0d exp 0/0", illegal, damage_out); end
        run_action(PLAYER1, 2'd0, 2'd0, ACT_ATTACK);
        checks++; if (damage_out !== 4'd1) begin errors++; $display("FAIL blocked_damage got %0d exp 1", damage_out); end
        run_action(PLAYER1, 2'd0, 2'd0, ACT_ATTACK);
        checks++; if (damage_out !== 4'd3) begin errors++; $display("FAIL unblocked_damage got %0d exp 3", damage_out); end
        checks++; if (defender_ko !== 1'b1) begin errors++; $display("FAIL ko got %0d exp 1", defender_ko); end
        peek(3'd4, word);
        checks++; if (word !== pet(3, 4, 0)) begin errors++; $display("FAIL ko_word got %h exp %h", word, pet(3, 4, 0)); end
        $display("test_block done");
    endtask

    task automatic test_illegal();
        run_action(PLAYER1, 2'd0, 2'd0, ACT_ATTACK);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_dead_target got %0d exp 1", illegal); end
        checks++; if ({damage_out, defender_ko} !== 5'd0) begin errors++;
            $display("FAIL illegal_result got %0d/%0d exp 0/0", damage_out, defender_ko); end
        checks++; if (busy_cnt !== 4 || lat !== 4) begin errors++;
            $display("FAIL illegal_busy got %0d/%0d exp 4/4", busy_cnt, lat); end
        run_action(PLAYER2, 2'd0, 2'd0, ACT_HEAL);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_dead_actor got %0d exp 1", illegal); end
        peek(3'd4, word);
        checks++; if (word !== pet(3, 4, 0)) begin errors++; $display("FAIL illegal_nowrite got %h exp %h", word, pet(3, 4, 0)); end
        $display("test_illegal done");
    endtask

    task automatic test_heal_and_wipe();
        run_action(PLAYER1, 2'd0, 2'd0, ACT_HEAL);
        checks++; if ({illegal, damage_out} !== 5'd0) begin errors++;
            $display("FAIL heal_result got %0d/%0d exp 0/0", illegal, damage_out); end
        peek(3'd0, word);
        checks++; if (word !== pet(5, 2, 7)) begin errors++; $display("FAIL heal_sat got %h exp %h", word, pet(5, 2, 7)); end
        for (int i = 5; i < 8; i++) load(3'(i), pet(0, 0, 1));
        for (int i = 1; i < 4; i++) begin
            run_action(PLAYER1, 2'd0, 2'(i), ACT_ATTACK);
            checks++; if (damage_out !== 4'd5 || defender_ko !== 1'b1) begin errors++;
                $display("FAIL wipe_kill%0d got %0d/%0d exp 5/1", i, damage_out, defender_ko); end
        end
        checks++; if (team_wiped !== 2'b10) begin errors++; $display("FAIL team_wiped got %b exp 10", team_wiped); end
        $display("test_heal_and_wipe done");
    endtask

    task automatic test_dropped_start();
        load(3'd1, pet(2, 1, 3));
        attacker_player = PLAYER1; attacker_idx = 2'd0; action = ACT_SKIP;
        start = 1'b1;
        tick();
        attacker_idx = 2'd1; action = ACT_HEAL;
        tick(); tick();
        start = 1'b0;
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_start_done got %0d exp 1", done); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_dropped got %0d exp 0", busy); end
        load_en = 1'b1; load_addr = 3'd2; load_data = pet(1, 1, 2);
        start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_start_dropped got %0d exp 0", busy); end
        peek(3'd2, word);
        checks++; if (word !== pet(1, 1, 2)) begin errors++; $display("FAIL load_landed got %h exp %h", word, pet(1, 1, 2)); end
        peek(3'd1, word);
        checks++; if (word !== pet(2, 1, 3)) begin errors++; $display("FAIL no_heal got %h exp %h", word, pet(2, 1, 3)); end
        $display("test_dropped_start done");
    endtask

    task automatic test_reset_mid();
        attacker_player = PLAYER1; attacker_idx = 2'd1; action = ACT_HEAL;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0d exp 0", busy); end
        checks++; if (team_wiped !== 2'b11) begin errors++; $display("FAIL midreset_wiped got %b exp 11", team_wiped); end
        tick(); tick(); tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %0d exp 0", done); end
        for (int i = 0; i < 8; i++) begin
            peek(3'(i), word);
            checks++; if (word !== 9'd0) begin errors++; $display("FAIL midreset_entry%0d got %h exp 0", i, word); end
        end
        $display("test_reset_mid done");
    endtask

`ifdef COMBAT_CRIT_EN
    task automatic test_crit();
        load(3'd3, pet(7, 0, 7));
        load(3'd7, pet(0, 0, 7));
        crit_roll = 8'd0;
        run_action(PLAYER1, 2'd3, 2'd3, ACT_ATTACK);
        checks++; if (damage_out !== 4'd14 || defender_ko !== 1'b1) begin errors++;
            $display("FAIL crit_hit got %0d/%0d exp 14/1", damage_out, defender_ko); end
        load(3'd7, pet(0, 0, 7));
        crit_roll = 8'd255;
        run_action(PLAYER1, 2'd3, 2'd3, ACT_ATTACK);
        checks++; if (damage_out !== 4'd7) begin errors++; $display("FAIL crit_miss got %0d exp 7", damage_out); end
        $display("test_crit done");
    endtask
`endif

    initial begin
        test_reset();
        test_attack();
        test_block();
        test_illegal();
        test_heal_and_wipe();
        test_dropped_start();
        test_reset_mid();
`ifdef COMBAT_CRIT_EN
        test_crit();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
